// File: rtl/comb_filter_mc.sv
// comb_filter_mc
//   Multi-channel feedback comb filter for the reverb path. All channels share
//   one delay RAM (CHANNELS*MAX_DEPTH words, channel c owns the block starting
//   at c*MAX_DEPTH). Each accepted frame is processed one channel at a time
//   (read, then write back), followed by a one-cycle output strobe.
//   Per channel: out = y, RAM <= sat(x>>>1 + ((y*g)>>>GAIN_W)), y = RAM[ptr].
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          1 = filter, 0 = bypass (input frame registered to output)
//   delay           delay length D in samples (0 -> 1, >MAX_DEPTH -> MAX_DEPTH)
//   fb_gain         unsigned Q0.GAIN_W feedback gain, used during each write-back
//   in_valid/ready  frame handshake; in_data packs channel 0 in the LSBs
//   out_valid       one-cycle strobe qualifying out_data
//   out_data        packed signed wet outputs
//   overrun         sticky: a frame was offered while in_ready was low
module comb_filter_mc #(
  parameter int WIDTH     = 32,
  parameter int MAX_DEPTH = 2048,
  parameter int CHANNELS  = 2,
  parameter int GAIN_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [$clog2(MAX_DEPTH):0]    delay,
  input  logic [GAIN_W-1:0]             fb_gain,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  output logic                          out_valid,
  output logic [CHANNELS*WIDTH-1:0]     out_data,
  output logic                          overrun
);

  localparam int PW    = $clog2(MAX_DEPTH);
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW    = CW + PW;
  localparam int DEPTH = CHANNELS * MAX_DEPTH;
  localparam int PRODW = WIDTH + GAIN_W + 1;
  localparam int SUMW  = WIDTH + GAIN_W + 2;

  localparam logic signed [SUMW-1:0] SAT_MAX = {{(SUMW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SUMW-1:0] SAT_MIN = {{(SUMW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_WR, S_DONE} state_t;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [SUMW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return v[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] fb_sum(input logic signed [WIDTH-1:0] x,
                                                     input logic signed [WIDTH-1:0] y,
                                                     input logic [GAIN_W-1:0]       g);
    logic signed [PRODW-1:0] ye, ge, prod;
    logic signed [SUMW-1:0]  sum;
    ye   = PRODW'(y);
    ge   = PRODW'($signed({1'b0, g}));
    prod = ye * ge;
    sum  = SUMW'(x >>> 1) + SUMW'(prod >>> GAIN_W);
    return sat(sum);
  endfunction

  function automatic logic [PW:0] clamp_delay(input logic [PW:0] dl);
    if (dl == '0)                        return (PW+1)'(1);
    else if (dl > (PW+1)'(MAX_DEPTH))    return (PW+1)'(MAX_DEPTH);
    else                                 return dl;
  endfunction

  state_t                       state_q, state_d;
  logic [AW-1:0]                clr_addr_q, clr_addr_d;
  logic [PW-1:0]                ptr_q, ptr_d;
  logic [PW:0]                  d_q, d_d;
  logic [CW-1:0]                ch_q, ch_d;
  logic [CHANNELS*WIDTH-1:0]    x_q, x_d;
  logic [CHANNELS*WIDTH-1:0]    out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         byp_pend_q, byp_pend_d;
  logic                         overrun_q, overrun_d;
  logic                         en_prev_q, en_prev_d;

  logic signed [WIDTH-1:0]      mem [DEPTH];
  logic signed [WIDTH-1:0]      ram_rdata;
  logic                         ram_we;
  logic [AW-1:0]                ram_addr;
  logic signed [WIDTH-1:0]      ram_wdata;
  logic                         clr_req;
  logic                         accept;
  logic [PW:0]                  d_eff;

  // A rising enable seen in IDLE forces a fresh CLEAR so bypass-era RAM
  // contents never leak into filtered output; hold off acceptance meanwhile.
  assign clr_req  = enable && !en_prev_q;
  assign in_ready = (state_q == S_IDLE) && !clr_req;
  assign accept   = in_valid && in_ready;
  assign d_eff    = clamp_delay(delay);

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    ptr_d       = ptr_q;
    d_d         = d_q;
    ch_d        = ch_q;
    x_d         = x_q;
    out_data_d  = out_data_q;
    out_valid_d = byp_pend_q;
    byp_pend_d  = 1'b0;
    overrun_d   = overrun_q || (in_valid && !in_ready);
    en_prev_d   = enable;
    ram_we      = 1'b0;
    ram_addr    = {ch_q, ptr_q};
    ram_wdata   = '0;
    case (state_q)
      S_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_addr_q;
        ptr_d    = '0;
        if (clr_addr_q == AW'(DEPTH-1)) begin
          clr_addr_d = '0;
          state_d    = S_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
        end else if (accept) begin
          if (enable) begin
            x_d   = in_data;
            d_d   = d_eff;
            ch_d  = '0;
            if ({1'b0, ptr_q} >= d_eff) ptr_d = '0;
            state_d = S_RD;
          end else begin
            out_data_d = in_data;
            byp_pend_d = 1'b1;
            ptr_d      = '0;
          end
        end
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        ram_we    = 1'b1;
        ram_wdata = fb_sum(x_q[ch_q*WIDTH +: WIDTH], ram_rdata, fb_gain);
        out_data_d[ch_q*WIDTH +: WIDTH] = ram_rdata;
        if (ch_q == CW'(CHANNELS-1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_DONE: begin
        out_valid_d = 1'b1;
        ptr_d       = ({1'b0, ptr_q} == d_q - 1'b1) ? '0 : ptr_q + 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // ---- control / output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR;
      clr_addr_q  <= '0;
      ptr_q       <= '0;
      d_q         <= (PW+1)'(1);
      ch_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      byp_pend_q  <= 1'b0;
      overrun_q   <= 1'b0;
      en_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      ptr_q       <= ptr_d;
      d_q         <= d_d;
      ch_q        <= ch_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      byp_pend_q  <= byp_pend_d;
      overrun_q   <= overrun_d;
      en_prev_q   <= en_prev_d;
    end
  end

  // ---- delay RAM (1-cycle read latency) and captured frame ----
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    x_q       <= x_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overrun   = overrun_q;

endmodule
